axi_burst_checker: RTL and testbench

AXI_BURST_CHECKER -- requirements
Module: axi_burst_checker

---
 rtl/axi_burst_checker_pkg.sv | 30 +++
 rtl/axi_burst_checker_pattern_gen.sv | 42 ++++
 rtl/axi_burst_checker.sv | 190 +++++++++++++++++++
 tb/tb_axi_burst_checker.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_checker_pkg.sv
// Shared definitions for the AXI4 burst checker.
//   state_t        : checker FSM states
//   AXI_* consts   : AXI4 encodings used on the address and response channels
//   pattern_word() : data expected on beat 'beat' of burst 'burst_idx'
package axi_burst_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // Incrementing pattern, wraps modulo 2^32.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [7:0]  burst_idx,
                                               input logic [8:0]  burst_len,
                                               input logic [7:0]  beat);
    return seed + (32'(burst_idx) * 32'(burst_len)) + 32'(beat);
  endfunction

endpackage

// File: rtl/axi_burst_checker_pattern_gen.sv
// Beat counter and data generator, shared by the write and read paths.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : return the beat counter to 0 (start of a run)
//   advance      : one beat accepted; wraps to 0 after the final beat
//   seed         : latched run seed
//   burst_idx    : current burst number
//   last_beat    : current beat is the final beat of the burst
//   data         : pattern word for the current beat
module axi_burst_pattern_gen
  import axi_burst_checker_pkg::*;
#(
  parameter int C_BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        advance,
  input  logic [31:0] seed,
  input  logic [7:0]  burst_idx,
  output logic        last_beat,
  output logic [31:0] data
);

  logic [7:0] beat_idx;

  assign last_beat = (beat_idx == 8'(C_BURST_LEN - 1));
  assign data      = pattern_word(seed, burst_idx, 9'(C_BURST_LEN), beat_idx);

  // Wrapping after the final write beat leaves the counter at 0 for the
  // read-back of the same burst, and again for the next burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
    end else if (clear) begin
      beat_idx <= '0;
    end else if (advance) begin
      beat_idx <= last_beat ? 8'd0 : beat_idx + 8'd1;
    end
  end

endmodule

// File: rtl/axi_burst_checker.sv
// AXI4 master that writes C_NUM_BURSTS incrementing INCR bursts, reads each
// one back and counts response/data/RLAST failures.
// Ports:
//   ACLK, ARESETN       : clock, asynchronous active-low reset
//   INIT_AXI_TXN        : rising edge starts a run (only from IDLE or DONE)
//   BASE_ADDR, SEED     : first burst address and data seed, latched at start
//   TXN_DONE            : run complete, held until the next accepted start
//   ERROR, ERR_CNT      : sticky error flag and saturating error count
//   AW/W/B/AR/R groups  : AXI4 master interface
module axi_burst_checker
  import axi_burst_checker_pkg::*;
#(
  parameter int C_BURST_LEN  = 8,
  parameter int C_NUM_BURSTS = 4,
  parameter int C_ADDR_W     = 32,
  parameter int C_DATA_W     = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  INIT_AXI_TXN,
  input  logic [C_ADDR_W-1:0]   BASE_ADDR,
  input  logic [31:0]           SEED,
  output logic                  TXN_DONE,
  output logic                  ERROR,
  output logic [15:0]           ERR_CNT,
  output logic [C_ADDR_W-1:0]   AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [C_DATA_W-1:0]   WDATA,
  output logic [C_DATA_W/8-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [C_ADDR_W-1:0]   ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [C_DATA_W-1:0]   RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  state_t              state;
  logic                init_q;
  logic [7:0]          burst_idx;
  logic [31:0]         seed_q;
  logic [C_ADDR_W-1:0] base_q;
  logic [C_ADDR_W-1:0] burst_addr;
  logic                last_beat;
  logic [31:0]         beat_data;
  logic                start_ok;
  logic                w_hs, b_hs, r_hs;
  logic                b_err, r_err;

  assign start_ok = INIT_AXI_TXN && !init_q && (state == ST_IDLE || state == ST_DONE);
  assign w_hs     = WVALID && WREADY;
  assign b_hs     = BVALID && BREADY;
  assign r_hs     = RVALID && RREADY;

  axi_burst_pattern_gen #(
    .C_BURST_LEN(C_BURST_LEN)
  ) u_pattern_gen (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .clear    (start_ok),
    .advance  (w_hs || r_hs),
    .seed     (seed_q),
    .burst_idx(burst_idx),
    .last_beat(last_beat),
    .data     (beat_data)
  );

  assign burst_addr = base_q + (C_ADDR_W'(burst_idx) * C_ADDR_W'(C_BURST_LEN * 4));

  assign AWADDR  = burst_addr;
  assign ARADDR  = burst_addr;
  assign AWLEN   = 8'(C_BURST_LEN - 1);
  assign ARLEN   = 8'(C_BURST_LEN - 1);
  assign AWSIZE  = AXI_SIZE_4B;
  assign ARSIZE  = AXI_SIZE_4B;
  assign AWBURST = AXI_BURST_INCR;
  assign ARBURST = AXI_BURST_INCR;
  assign WSTRB   = '1;
  assign WDATA   = C_DATA_W'(beat_data);
  assign WLAST   = WVALID && last_beat;

  // B and R handshakes never share a cycle, and every read-beat failure is
  // folded into one flag, so each beat contributes at most one count.
  assign b_err = b_hs && (BRESP != AXI_RESP_OKAY);
  assign r_err = r_hs && ((RRESP != AXI_RESP_OKAY) ||
                          (RDATA != C_DATA_W'(beat_data)) ||
                          (RLAST != last_beat));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      init_q    <= 1'b0;
      burst_idx <= '0;
      seed_q    <= '0;
      base_q    <= '0;
      TXN_DONE  <= 1'b0;
      ERROR     <= 1'b0;
      ERR_CNT   <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;

      if (b_err || r_err) begin
        ERROR <= 1'b1;
        if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state     <= ST_WR_ADDR;
            AWVALID   <= 1'b1;
            TXN_DONE  <= 1'b0;
            ERROR     <= 1'b0;
            ERR_CNT   <= '0;
            burst_idx <= '0;
            seed_q    <= SEED;
            base_q    <= BASE_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            WVALID  <= 1'b1;
            state   <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (WREADY && last_beat) begin
            WVALID <= 1'b0;
            BREADY <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            BREADY  <= 1'b0;
            ARVALID <= 1'b1;
            state   <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // Exit on the beat count alone; RLAST only feeds the error check.
          if (RVALID && last_beat) begin
            RREADY <= 1'b0;
            state  <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (burst_idx < 8'(C_NUM_BURSTS - 1)) begin
            burst_idx <= burst_idx + 8'd1;
            AWVALID   <= 1'b1;
            state     <= ST_WR_ADDR;
          end else begin
            TXN_DONE <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_checker.sv
// Directed bench for axi_burst_checker with a small AXI slave memory model.
module tb_axi_burst_checker;

  localparam int LEN = 8;
  localparam int NUM = 4;

  logic        ACLK, ARESETN, INIT_AXI_TXN;
  logic [31:0] BASE_ADDR, SEED;
  logic        TXN_DONE, ERROR;
  logic [15:0] ERR_CNT;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int failures = 0;

  // slave model state and configuration
  logic [31:0] mem [256];
  logic [31:0] aw_log [16];
  logic [7:0]  wr_ptr, rd_ptr;
  int wr_cnt, rd_cnt, w_total, aw_cnt, b_idx, rd_burst;
  int wlast_err, stab_err;
  bit r_act, b_pend, bp_en;
  int corrupt_burst, corrupt_beat, early_burst, slverr_burst;
  bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
  logic        w_last_s;
  bit prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
  logic        prev_wlast;

  axi_burst_checker #(
    .C_BURST_LEN(LEN), .C_NUM_BURSTS(NUM), .C_ADDR_W(32), .C_DATA_W(32)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .INIT_AXI_TXN(INIT_AXI_TXN),
    .BASE_ADDR(BASE_ADDR), .SEED(SEED),
    .TXN_DONE(TXN_DONE), .ERROR(ERROR), .ERR_CNT(ERR_CNT),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave: acts on the negedge. Handshakes recorded at one negedge are the
  // ones the DUT sees at the following posedge, and are applied at the next.
  initial begin
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; BRESP = 0;
    RVALID = 0; RLAST = 0; RRESP = 0; RDATA = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; BRESP = 0;
        RVALID = 0; RLAST = 0; RRESP = 0; RDATA = 0;
        r_act = 0; b_pend = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        prev_awv = 0; prev_wv = 0; prev_arv = 0;
      end else begin
        if (aw_fire) begin
          wr_ptr = aw_addr_s[9:2];
          wr_cnt = 0;
          if (aw_cnt < 16) aw_log[aw_cnt] = aw_addr_s;
          aw_cnt++;
        end
        if (w_fire) begin
          mem[wr_ptr] = w_data_s;
          if (w_last_s !== (wr_cnt == LEN - 1)) wlast_err++;
          wr_ptr++;
          wr_cnt++;
          w_total++;
          if (wr_cnt == LEN) b_pend = 1;
        end
        if (b_fire) begin
          BVALID = 0; BRESP = 0; b_idx++;
        end
        if (ar_fire) begin
          rd_ptr = ar_addr_s[9:2]; rd_cnt = 0; r_act = 1;
        end
        if (r_fire) begin
          RVALID = 0; RLAST = 0;
          rd_ptr++;
          rd_cnt++;
          if (rd_cnt == LEN) begin
            r_act = 0; rd_burst++;
          end
        end
        AWREADY = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        WREADY  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        ARREADY = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_pend && !BVALID && (!bp_en || $urandom_range(0, 1) == 1)) begin
          BVALID = 1;
          BRESP  = (b_idx == slverr_burst) ? 2'b10 : 2'b00;
          b_pend = 0;
        end
        if (r_act && !RVALID && (!bp_en || $urandom_range(0, 1) == 1)) begin
          RVALID = 1;
          RRESP  = 2'b00;
          RDATA  = mem[rd_ptr] ^ ((rd_burst == corrupt_burst && rd_cnt == corrupt_beat) ? 32'h100 : 32'h0);
          RLAST  = (rd_cnt == LEN - 1) || (rd_burst == early_burst && rd_cnt == 5);
        end
        // a VALID left waiting at the last edge must still be up and unchanged
        if (prev_awv && !prev_awr && (AWVALID !== 1'b1 || AWADDR !== prev_awaddr)) stab_err++;
        if (prev_wv && !prev_wr && (WVALID !== 1'b1 || WDATA !== prev_wdata || WLAST !== prev_wlast)) stab_err++;
        if (prev_arv && !prev_arr && (ARVALID !== 1'b1 || ARADDR !== prev_araddr)) stab_err++;
        aw_fire = AWVALID && AWREADY; aw_addr_s = AWADDR;
        w_fire  = WVALID && WREADY;   w_data_s = WDATA; w_last_s = WLAST;
        b_fire  = BVALID && BREADY;
        ar_fire = ARVALID && ARREADY; ar_addr_s = ARADDR;
        r_fire  = RVALID && RREADY;
        prev_awv = AWVALID; prev_awr = AWREADY; prev_awaddr = AWADDR;
        prev_wv = WVALID; prev_wr = WREADY; prev_wdata = WDATA; prev_wlast = WLAST;
        prev_arv = ARVALID; prev_arr = ARREADY; prev_araddr = ARADDR;
      end
    end
  end

  task automatic slave_clear();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) aw_log[i] = 32'hFFFF_FFFF;
    w_total = 0; aw_cnt = 0; b_idx = 0; rd_burst = 0;
    wlast_err = 0; stab_err = 0; bp_en = 0;
    corrupt_burst = -1; corrupt_beat = -1; early_burst = -1; slverr_burst = -1;
  endtask

  task automatic pulse_start();
    @(negedge ACLK); INIT_AXI_TXN = 1'b1;
    @(negedge ACLK); INIT_AXI_TXN = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && TXN_DONE !== 1'b1; i++) @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; INIT_AXI_TXN = 1'b0; BASE_ADDR = '0; SEED = '0;
    slave_clear();
    repeat (3) @(negedge ACLK);
    checks++;
    if ({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY} !== 6'b0)
      begin failures++; $display("[TB] FAIL reset_handshake: got %b required 000000", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY}); end
    checks++;
    if ({TXN_DONE, ERROR, ERR_CNT} !== 18'h0)
      begin failures++; $display("[TB] FAIL reset_status: done=%b err=%b cnt=%0d required 0 0 0", TXN_DONE, ERROR, ERR_CNT); end
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
    checks++;
    if (AWVALID !== 1'b0)
      begin failures++; $display("[TB] FAIL reset_idle_wait: AWVALID=%b required 0", AWVALID); end
  endtask

  task automatic test_basic();
    slave_clear();
    SEED = 32'h0; BASE_ADDR = 32'h0;
    pulse_start();
    checks++;
    if (AWLEN !== 8'd7 || AWSIZE !== 3'b010 || AWBURST !== 2'b01 || WSTRB !== 4'hF ||
        ARLEN !== 8'd7 || ARSIZE !== 3'b010 || ARBURST !== 2'b01)
      begin failures++; $display("[TB] FAIL basic_attrs: len=%h size=%b burst=%b strb=%h required 07 010 01 f", AWLEN, AWSIZE, AWBURST, WSTRB); end
    wait_done(2000);
    checks++;
    if (TXN_DONE !== 1'b1) begin failures++; $display("[TB] FAIL basic_done: got %b required 1", TXN_DONE); end
    checks++;
    if (ERROR !== 1'b0 || ERR_CNT !== 16'd0)
      begin failures++; $display("[TB] FAIL basic_error: err=%b cnt=%0d required 0 0", ERROR, ERR_CNT); end
    checks++;
    if (w_total !== 32 || wlast_err !== 0 || stab_err !== 0)
      begin failures++; $display("[TB] FAIL basic_beats: beats=%0d wlast_err=%0d stab_err=%0d required 32 0 0", w_total, wlast_err, stab_err); end
    for (int b = 0; b < NUM; b++) begin
      checks++;
      if (aw_log[b] !== 32'(b * 32))
        begin failures++; $display("[TB] FAIL basic_awaddr[%0d]: got %h required %h", b, aw_log[b], 32'(b * 32)); end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[i] !== 32'(i))
        begin failures++; $display("[TB] FAIL basic_mem[%0d]: got %h required %h", i, mem[i], 32'(i)); end
    end
  endtask

  task automatic test_backpressure();
    slave_clear();
    bp_en = 1;
    SEED = 32'hFFFF_FFFE; BASE_ADDR = 32'h200;
    pulse_start();
    wait_done(3000);
    checks++;
    if (TXN_DONE !== 1'b1 || ERROR !== 1'b0 || ERR_CNT !== 16'd0)
      begin failures++; $display("[TB] FAIL bp_status: done=%b err=%b cnt=%0d required 1 0 0", TXN_DONE, ERROR, ERR_CNT); end
    checks++;
    if (stab_err !== 0 || wlast_err !== 0 || w_total !== 32)
      begin failures++; $display("[TB] FAIL bp_protocol: stab_err=%0d wlast_err=%0d beats=%0d required 0 0 32", stab_err, wlast_err, w_total); end
    checks++;
    if (mem[130] !== 32'h0)
      begin failures++; $display("[TB] FAIL bp_wrap: beat2=%h required 00000000", mem[130]); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[128 + i] !== 32'hFFFF_FFFE + 32'(i))
        begin failures++; $display("[TB] FAIL bp_mem[%0d]: got %h required %h", i, mem[128 + i], 32'hFFFF_FFFE + 32'(i)); end
    end
    checks++;
    if (aw_log[3] !== 32'h260)
      begin failures++; $display("[TB] FAIL bp_awaddr3: got %h required 00000260", aw_log[3]); end
    bp_en = 0;
  endtask

  task automatic test_corrupt();
    slave_clear();
    corrupt_burst = 2; corrupt_beat = 3;
    SEED = 32'h100; BASE_ADDR = 32'h0;
    pulse_start();
    wait_done(2000);
    checks++;
    if (TXN_DONE !== 1'b1 || ERROR !== 1'b1 || ERR_CNT !== 16'd1)
      begin failures++; $display("[TB] FAIL corrupt_status: done=%b err=%b cnt=%0d required 1 1 1", TXN_DONE, ERROR, ERR_CNT); end
  endtask

  // SLVERR on the second write response, plus an extra RLAST on beat 5 of
  // burst 0 (the final beat still carries RLAST): two counted errors.
  task automatic test_slverr_rlast();
    slave_clear();
    slverr_burst = 1; early_burst = 0;
    SEED = 32'h1234_0000; BASE_ADDR = 32'h100;
    pulse_start();
    checks++;
    if (ERROR !== 1'b0 || ERR_CNT !== 16'd0)
      begin failures++; $display("[TB] FAIL start_clears_err: err=%b cnt=%0d required 0 0", ERROR, ERR_CNT); end
    wait_done(2000);
    checks++;
    if (TXN_DONE !== 1'b1 || ERROR !== 1'b1 || ERR_CNT !== 16'd2)
      begin failures++; $display("[TB] FAIL slverr_status: done=%b err=%b cnt=%0d required 1 1 2", TXN_DONE, ERROR, ERR_CNT); end
  endtask

  task automatic test_reset_midburst();
    slave_clear();
    SEED = 32'h40; BASE_ADDR = 32'h0;
    pulse_start();
    for (int i = 0; i < 200 && w_total != 3; i++) begin
      @(negedge ACLK); #1;
    end
    checks++;
    if (w_total !== 3 || WVALID !== 1'b1)
      begin failures++; $display("[TB] FAIL mid_reach_beat3: beats=%0d wvalid=%b required 3 1", w_total, WVALID); end
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, TXN_DONE, ERROR} !== 8'b0 || ERR_CNT !== 16'd0)
      begin failures++; $display("[TB] FAIL mid_reset_outputs: got %b cnt=%0d required 00000000 0", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, TXN_DONE, ERROR}, ERR_CNT); end
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b0 || w_total !== 3)
      begin failures++; $display("[TB] FAIL mid_no_resume: awvalid=%b wvalid=%b beats=%0d required 0 0 3", AWVALID, WVALID, w_total); end
    slave_clear();
    pulse_start();
    wait_done(2000);
    checks++;
    if (TXN_DONE !== 1'b1 || ERROR !== 1'b0 || ERR_CNT !== 16'd0 || w_total !== 32)
      begin failures++; $display("[TB] FAIL mid_rerun: done=%b err=%b cnt=%0d beats=%0d required 1 0 0 32", TXN_DONE, ERROR, ERR_CNT, w_total); end
    checks++;
    if (mem[31] !== 32'h5F)
      begin failures++; $display("[TB] FAIL mid_rerun_data: got %h required 0000005f", mem[31]); end
  endtask

  task automatic test_back_to_back();
    slave_clear();
    SEED = 32'h7; BASE_ADDR = 32'h0;
    pulse_start();
    repeat (20) @(negedge ACLK);
    pulse_start();
    wait_done(2000);
    checks++;
    if (TXN_DONE !== 1'b1 || aw_cnt !== NUM || w_total !== 32)
      begin failures++; $display("[TB] FAIL busy_ignored: done=%b bursts=%0d beats=%0d required 1 4 32", TXN_DONE, aw_cnt, w_total); end
    pulse_start();
    checks++;
    if (TXN_DONE !== 1'b0 || AWVALID !== 1'b1)
      begin failures++; $display("[TB] FAIL done_restart: done=%b awvalid=%b required 0 1", TXN_DONE, AWVALID); end
    wait_done(2000);
    checks++;
    if (TXN_DONE !== 1'b1 || aw_cnt !== 2 * NUM || w_total !== 64 || ERR_CNT !== 16'd0)
      begin failures++; $display("[TB] FAIL done_rerun: done=%b bursts=%0d beats=%0d cnt=%0d required 1 8 64 0", TXN_DONE, aw_cnt, w_total, ERR_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_corrupt();
    test_slverr_rlast();
    test_reset_midburst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
